// File: rtl/mic_pkg.sv
// Shared types and helpers for the microphone sample framer.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package mic_pkg;

  // Reader states: wait for a full bank, prime the read register, stream the frame out
  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  // Ceiling log2, used at elaboration to size the frame index
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Round half up by 2^s, then clamp to a signed ow-bit range
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] value,
                                                   input int s, input int ow);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = value;
    if (s > 0) r = (value + (64'sd1 <<< (s - 1))) >>> s;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/mic_dc_block.sv
// Leaky-integrator DC removal, then round/saturate to OUTWIDTH.
// Latency: 1 cycle from accepted strobe to q_vld.
// Backpressure: none; every accepted strobe yields one q_vld pulse.
module mic_dc_block
  import mic_pkg::*;
#(
  parameter int DATAWIDTH = 24,
  parameter int OUTWIDTH  = 16,
  parameter int DC_SHIFT  = 10
) (
  input  logic                 clk_mic,
  input  logic                 rst_mic_n,
  input  logic                 en,
  input  logic                 soft_clr,
  input  logic [DATAWIDTH-1:0] smp_data,
  input  logic                 smp_vld,
  output logic [OUTWIDTH-1:0]  q,
  output logic                 q_vld
);

  localparam int AW = DATAWIDTH + DC_SHIFT + 1;
  localparam int S  = DATAWIDTH - OUTWIDTH;

  logic signed [AW-1:0]      acc;
  logic signed [DATAWIDTH:0] dc;
  logic signed [DATAWIDTH:0] y;
  logic signed [AW-1:0]      smp_ext;
  logic signed [AW-1:0]      dc_ext;
  logic                      take;

  assign take    = smp_vld && en && !soft_clr;
  // DC estimate is the accumulator scaled down by the pole weight, taken before this update
  assign dc      = acc[AW-1:DC_SHIFT];
  assign y       = {smp_data[DATAWIDTH-1], smp_data} - dc;
  assign smp_ext = {{(DC_SHIFT + 1){smp_data[DATAWIDTH-1]}}, smp_data};
  assign dc_ext  = {{DC_SHIFT{dc[DATAWIDTH]}}, dc};

  // Accumulator tracks the input mean; output register holds the scaled high-passed sample
  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      acc   <= '0;
      q     <= '0;
      q_vld <= 1'b0;
    end else if (soft_clr) begin
      acc   <= '0;
      q     <= '0;
      q_vld <= 1'b0;
    end else begin
      q_vld <= take;
      if (take) begin
        acc <= acc + smp_ext - dc_ext;
        q   <= OUTWIDTH'(round_sat({{(63 - DATAWIDTH){y[DATAWIDTH]}}, y}, S, OUTWIDTH));
      end
    end
  end

endmodule

// File: rtl/mic_sample_framer.sv
// DC-blocked samples packed into ping-pong frames and streamed out on valid/ready.
// Latency: first word valid 2 cycles after the frame's last strobe when the reader is idle.
// Backpressure: m_tready stalls the stream; with both banks full, new samples are dropped and counted.
module mic_sample_framer
  import mic_pkg::*;
#(
  parameter int DATAWIDTH = 24,
  parameter int OUTWIDTH  = 16,
  parameter int FRAME_LEN = 256,
  parameter int DC_SHIFT  = 10
) (
  input  logic                 clk_mic,
  input  logic                 rst_mic_n,
  input  logic                 en,
  input  logic                 soft_clr,
  input  logic [DATAWIDTH-1:0] smp_data,
  input  logic                 smp_vld,
  output logic [OUTWIDTH-1:0]  m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 ovf,
  output logic [15:0]          drop_cnt
);

  localparam int            IW       = clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  logic [OUTWIDTH-1:0] q;
  logic                q_vld;
  logic                wr_bank;
  logic [IW-1:0]       wr_idx;
  logic [1:0]          full;
  logic                blocked;
  logic                wr_fire;
  logic                wr_done;
  rd_state_t           rd_state;
  logic                rd_bank;
  logic [IW-1:0]       rd_idx;
  logic [IW-1:0]       rd_addr_idx;
  logic                rd_en;
  logic                rd_free;
  logic                rd_avail;
  logic [OUTWIDTH-1:0] mem [0:2*FRAME_LEN-1];

  mic_dc_block #(
    .DATAWIDTH(DATAWIDTH),
    .OUTWIDTH (OUTWIDTH),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc (
    .clk_mic  (clk_mic),
    .rst_mic_n(rst_mic_n),
    .en       (en),
    .soft_clr (soft_clr),
    .smp_data (smp_data),
    .smp_vld  (smp_vld),
    .q        (q),
    .q_vld    (q_vld)
  );

  // A bank being released this cycle counts as free, so the writer never drops on that edge
  assign rd_free  = (rd_state == RD_STREAM) && m_tready && (rd_idx == LAST_IDX);
  assign blocked  = full[wr_bank] && !(rd_free && (rd_bank == wr_bank));
  assign wr_fire  = q_vld && !blocked;
  assign wr_done  = wr_fire && (wr_idx == LAST_IDX);
  // Banks fill strictly alternately, so the reader's next bank is always the older one
  assign rd_avail = full[rd_bank] || (wr_done && (wr_bank == rd_bank));
  // Read address never depends on m_tready; ready only enables the read register
  assign rd_addr_idx = (rd_state == RD_FETCH) ? '0 : rd_idx + 1'b1;
  assign rd_en       = (rd_state == RD_FETCH) ||
                       ((rd_state == RD_STREAM) && m_tready && (rd_idx != LAST_IDX));

  // Writer: fill the current bank, mark it full on the last word, switch banks, count drops
  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      full     <= 2'b00;
      ovf      <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (soft_clr) begin
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      full     <= 2'b00;
      ovf      <= 1'b0;
      drop_cnt <= 16'd0;
    end else begin
      if (rd_free) full[rd_bank] <= 1'b0;
      if (wr_done) full[wr_bank] <= 1'b1;
      if (wr_fire) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (q_vld && blocked) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Ping-pong buffer write port
  always_ff @(posedge clk_mic) begin
    if (wr_fire && !soft_clr) mem[{wr_bank, wr_idx}] <= q;
  end

  // Registered read port; doubles as the output data register and holds while stalled
  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      m_tdata <= '0;
    end else if (soft_clr) begin
      m_tdata <= '0;
    end else if (rd_en) begin
      m_tdata <= mem[{rd_bank, rd_addr_idx}];
    end
  end

  // Reader FSM: wait for the next bank, prime word 0, stream until the tlast handshake
  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_idx   <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (soft_clr) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_idx   <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_avail) rd_state <= RD_FETCH;
        end
        RD_FETCH: begin
          rd_idx   <= '0;
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b0;
          rd_state <= RD_STREAM;
        end
        RD_STREAM: begin
          if (m_tready) begin
            if (rd_idx == LAST_IDX) begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              rd_bank  <= ~rd_bank;
              rd_state <= RD_IDLE;
            end else begin
              rd_idx  <= rd_addr_idx;
              m_tlast <= (rd_addr_idx == LAST_IDX);
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_sample_framer.sv
// Directed bench for mic_sample_framer at default parameters.
// Latency: checks first-word timing against the last strobe of a frame.
// Backpressure: exercises held-low, random and always-high m_tready.
module tb_mic_sample_framer;

  logic        clk_mic = 1'b0;
  logic        rst_mic_n;
  logic        en;
  logic        soft_clr;
  logic [23:0] smp_data;
  logic        smp_vld;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        ovf;
  logic [15:0] drop_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_edge;
  int          stable_err;
  bit          timed_out;
  longint      macc;
  logic [15:0] exp_q[$];
  logic [15:0] got_dat[$];
  logic        got_last[$];
  int          got_cyc[$];

  mic_sample_framer dut (
    .clk_mic  (clk_mic),
    .rst_mic_n(rst_mic_n),
    .en       (en),
    .soft_clr (soft_clr),
    .smp_data (smp_data),
    .smp_vld  (smp_vld),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk_mic = ~clk_mic;
  always @(posedge clk_mic) cyc <= cyc + 1;

  // Reference: high-pass with weight 2^-10, round half up by 2^8, clamp to 16 bits
  task automatic model(input int s, output int qx);
    longint dc, y, r;
    dc = macc >>> 10;
    y  = longint'(s) - dc;
    r  = (y + 128) >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    macc = macc + y;
    qx = int'(r);
  endtask

  // Strobes: first value v0, then vr + i*step, one strobe every gap cycles
  task automatic drive(input int n, input int v0, input int vr, input int step,
                       input bit keep, input int gap);
    int qx, v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_mic);
      v = (i == 0) ? v0 : vr + i * step;
      smp_vld  = 1'b1;
      smp_data = 24'(v);
      model(v, qx);
      if (keep) exp_q.push_back(16'(qx));
      last_edge = cyc + 1;
      for (int g = 1; g < gap; g++) begin
        @(negedge clk_mic);
        smp_vld = 1'b0;
      end
    end
    @(negedge clk_mic);
    smp_vld = 1'b0;
  endtask

  // Consumer: drives m_tready at pct percent and records every handshake
  task automatic collect(input int nwords, input int pct, input int budget);
    int          cycles;
    logic        prev_stall;
    logic [15:0] prev_dat;
    logic        prev_last;
    cycles = 0;
    prev_stall = 1'b0;
    prev_dat = '0;
    prev_last = 1'b0;
    got_dat.delete();
    got_last.delete();
    got_cyc.delete();
    timed_out = 1'b0;
    stable_err = 0;
    while (got_dat.size() < nwords && !timed_out) begin
      @(negedge clk_mic);
      if (prev_stall && (!m_tvalid || m_tdata !== prev_dat || m_tlast !== prev_last))
        stable_err++;
      m_tready = (int'($urandom_range(0, 99)) < pct);
      if (m_tvalid && m_tready) begin
        got_dat.push_back(m_tdata);
        got_last.push_back(m_tlast);
        got_cyc.push_back(cyc);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat = m_tdata;
      prev_last = m_tlast;
      cycles++;
      if (cycles >= budget) timed_out = 1'b1;
    end
  endtask

  task automatic do_clr();
    @(negedge clk_mic);
    soft_clr = 1'b1;
    @(negedge clk_mic);
    soft_clr = 1'b0;
    macc = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_mic_n = 1'b0;
    en = 1'b1;
    soft_clr = 1'b0;
    smp_data = '0;
    smp_vld = 1'b0;
    m_tready = 1'b0;
    macc = 0;
    repeat (3) @(negedge clk_mic);
    n_cmp++; if (m_tdata !== 16'h0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0000", m_tdata); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt); end
    rst_mic_n = 1'b1;
    @(negedge clk_mic);
  endtask

  task automatic test_dc_frame();
    int nonmono;
    do_clr();
    fork
      drive(256, 32'h100000, 32'h100000, 0, 1'b1, 1);
      collect(256, 100, 2000);
    join
    n_cmp++; if (timed_out || got_dat.size() != 256) begin n_bad++; $display("FAIL dc_count: got %0d words want 256", got_dat.size()); end
    n_cmp++; if (got_dat[0] !== 16'h1000) begin n_bad++; $display("FAIL dc_first: got %h want 1000", got_dat[0]); end
    n_cmp++; if (got_cyc[0] - last_edge > 2) begin n_bad++; $display("FAIL dc_latency: got %0d cycles want <=2", got_cyc[0] - last_edge); end
    nonmono = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0 && $signed(got_dat[i]) >= $signed(got_dat[i-1])) nonmono++;
      n_cmp++;
      if (got_dat[i] !== exp_q[i] || got_last[i] !== (i == 255) || got_cyc[i] !== got_cyc[0] + i) begin
        n_bad++;
        $display("FAIL dc_word[%0d]: got %h last %b cyc %0d want %h last %b cyc %0d",
                 i, got_dat[i], got_last[i], got_cyc[i], exp_q[i], i == 255, got_cyc[0] + i);
      end
    end
    n_cmp++; if (nonmono !== 0) begin n_bad++; $display("FAIL dc_monotonic: got %0d rises want 0", nonmono); end
    exp_q.delete();
  endtask

  task automatic test_saturation();
    int          samples[3];
    logic [15:0] want[3];
    samples = '{8388607, -8388608, 128};
    want    = '{16'h7FFF, 16'h8000, 16'h0001};
    for (int k = 0; k < 3; k++) begin
      do_clr();
      fork
        drive(256, samples[k], 0, 0, 1'b1, 1);
        collect(256, 100, 2000);
      join
      n_cmp++;
      if (timed_out || got_dat[0] !== want[k]) begin
        n_bad++;
        $display("FAIL sat[%0d]: got %h timeout %b want %h", k, got_dat[0], timed_out, want[k]);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    do_clr();
    m_tready = 1'b0;
    drive(256, 32'h100000, 32'h100000, 0, 1'b1, 1);
    drive(256, 32'h100000, 32'h100000, 0, 1'b1, 1);
    drive(256, 32'h100000, 32'h100000, 0, 1'b0, 1);
    repeat (2) @(negedge clk_mic);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
    n_cmp++; if (drop_cnt !== 16'd256) begin n_bad++; $display("FAIL ovf_drop_cnt: got %0d want 256", drop_cnt); end
    collect(512, 100, 2000);
    n_cmp++; if (timed_out || got_dat.size() != 512) begin n_bad++; $display("FAIL ovf_count: got %0d words want 512", got_dat.size()); end
    for (int i = 0; i < 512; i++) begin
      n_cmp++;
      if (got_dat[i] !== exp_q[i] || got_last[i] !== (i == 255 || i == 511)) begin
        n_bad++;
        $display("FAIL ovf_word[%0d]: got %h last %b want %h last %b", i, got_dat[i], got_last[i], exp_q[i], i == 255 || i == 511);
      end
    end
    exp_q.delete();
    fork
      drive(256, 32'h100000, 32'h100000, 0, 1'b1, 1);
      collect(256, 100, 2000);
    join
    n_cmp++; if (timed_out || got_dat.size() != 256) begin n_bad++; $display("FAIL resume_count: got %0d words want 256", got_dat.size()); end
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (got_dat[i] !== exp_q[i] || got_last[i] !== (i == 255)) begin
        n_bad++;
        $display("FAIL resume_word[%0d]: got %h last %b want %h last %b", i, got_dat[i], got_last[i], exp_q[i], i == 255);
      end
    end
    n_cmp++; if (drop_cnt !== 16'd256) begin n_bad++; $display("FAIL resume_drop_cnt: got %0d want 256", drop_cnt); end
    exp_q.delete();
  endtask

  task automatic test_soft_clr();
    fork
      drive(256, 32'h100000, 32'h100000, 0, 1'b1, 1);
      collect(100, 100, 2000);
    join
    soft_clr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      n_cmp++;
      if (got_dat[i] !== exp_q[i]) begin n_bad++; $display("FAIL clr_word[%0d]: got %h want %h", i, got_dat[i], exp_q[i]); end
    end
    @(negedge clk_mic);
    soft_clr = 1'b0;
    macc = 0;
    exp_q.delete();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL clr_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL clr_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL clr_ovf: got %b want 0", ovf); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_drop_cnt: got %0d want 0", drop_cnt); end
    fork
      drive(256, 32'h100000, 32'h100000, 0, 1'b1, 1);
      collect(256, 100, 2000);
    join
    n_cmp++; if (timed_out || got_dat[0] !== 16'h1000) begin n_bad++; $display("FAIL clr_first: got %h want 1000", got_dat[0]); end
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (got_dat[i] !== exp_q[i] || got_last[i] !== (i == 255)) begin
        n_bad++;
        $display("FAIL clr_word2[%0d]: got %h last %b want %h last %b", i, got_dat[i], got_last[i], exp_q[i], i == 255);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random_ready();
    do_clr();
    fork
      drive(1024, 0, 0, 4096, 1'b1, 3);
      collect(1024, 50, 8000);
    join
    n_cmp++; if (timed_out || got_dat.size() != 1024) begin n_bad++; $display("FAIL rnd_count: got %0d words want 1024", got_dat.size()); end
    for (int i = 0; i < 1024; i++) begin
      n_cmp++;
      if (got_dat[i] !== exp_q[i] || got_last[i] !== ((i % 256) == 255)) begin
        n_bad++;
        $display("FAIL rnd_word[%0d]: got %h last %b want %h last %b", i, got_dat[i], got_last[i], exp_q[i], (i % 256) == 255);
      end
    end
    n_cmp++; if (stable_err !== 0) begin n_bad++; $display("FAIL rnd_stable: got %0d changes while stalled want 0", stable_err); end
    n_cmp++; if (drop_cnt !== 16'd0 || ovf !== 1'b0) begin n_bad++; $display("FAIL rnd_no_drop: got drop %0d ovf %b want 0/0", drop_cnt, ovf); end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    do_clr();
    fork
      drive(256, 32'h100000, 32'h100000, 0, 1'b1, 1);
      collect(50, 100, 2000);
    join
    n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL arst_pre_tvalid: got %b want 1", m_tvalid); end
    #2;
    rst_mic_n = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL arst_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tdata !== 16'h0) begin n_bad++; $display("FAIL arst_tdata: got %h want 0000", m_tdata); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL arst_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin n_bad++; $display("FAIL arst_ovf: got %b/%0d want 0/0", ovf, drop_cnt); end
    repeat (2) @(negedge clk_mic);
    rst_mic_n = 1'b1;
    macc = 0;
    exp_q.delete();
    fork
      drive(256, 32'h080000, 32'h080000, 0, 1'b1, 1);
      collect(256, 100, 2000);
    join
    n_cmp++; if (timed_out || got_dat.size() != 256) begin n_bad++; $display("FAIL arst_count: got %0d words want 256", got_dat.size()); end
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (got_dat[i] !== exp_q[i] || got_last[i] !== (i == 255)) begin
        n_bad++;
        $display("FAIL arst_word[%0d]: got %h last %b want %h last %b", i, got_dat[i], got_last[i], exp_q[i], i == 255);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_dc_frame();
    test_saturation();
    test_overflow();
    test_soft_clr();
    test_random_ready();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
